// File: rtl/uart_boot_loader.sv
// UART boot loader: receives 8N1 bytes, packs them big-endian into 32-bit
// words and streams them into instruction memory. Holds the CPU in reset
// until a terminator word (all ones) arrives or memory fills up.
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic [7:0]        rx_data,
  output logic              rx_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [31:0]       memdata,
  output logic [32:0]       rx_check,
  output logic [32:0]       rx_checkh,
  output logic [32:0]       rx_checkl,
  output logic              cpu_reset,
  output logic              done,
  output logic              frame_err
);

  localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] ADR_MAX  = '1;
  localparam logic [31:0]       TERM_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t             state, state_nx;
  logic [1:0]         rx_sync;
  logic               rxs;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         bit_cnt;
  logic [7:0]         shreg;
  logic               err_hold;
  logic [31:0]        asm_word;
  logic [1:0]         byte_cnt;
  logic               word_rdy;
  logic [31:0]        last_word;

  // FSM control strobes
  logic cnt_clr, cnt_inc, bit_take, byte_ok, byte_bad, hold_clr;

  assign rxs = rx_sync[1];

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (reset) rx_sync <= 2'b11;
    else       rx_sync <= {rx_sync[0], rx};
  end

  // Receiver state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    bit_take = 1'b0;
    byte_ok  = 1'b0;
    byte_bad = 1'b0;
    hold_clr = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_clr = 1'b1;
        // after a framing error the line must return high before re-arming
        if (err_hold) begin
          if (rxs) hold_clr = 1'b1;
        end else if (!rxs) begin
          state_nx = S_START;
        end
      end
      S_START: begin
        if (cnt == CNT_HALF) begin
          cnt_clr  = 1'b1;
          state_nx = rxs ? S_IDLE : S_DATA;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_clr  = 1'b1;
          bit_take = 1'b1;
          if (bit_cnt == 3'd7) state_nx = S_STOP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_clr  = 1'b1;
          state_nx = S_IDLE;
          if (rxs) byte_ok  = 1'b1;
          else     byte_bad = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Baud counter, bit counter and LSB-first shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (bit_take) begin
        bit_cnt <= bit_cnt + 1'b1;
        shreg   <= {rxs, shreg[7:1]};
      end
    end
  end

  // Received-byte output and sticky framing error
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      err_hold  <= 1'b0;
    end else begin
      rx_valid <= byte_ok;
      if (byte_ok) rx_data <= shreg;
      if (byte_bad) begin
        frame_err <= 1'b1;
        err_hold  <= 1'b1;
      end else if (hold_clr) begin
        err_hold <= 1'b0;
      end
    end
  end

  // Big-endian word assembly; word_rdy flags the fourth byte of a word
  always_ff @(posedge clk) begin
    if (reset) begin
      asm_word <= '0;
      byte_cnt <= '0;
      word_rdy <= 1'b0;
    end else begin
      word_rdy <= byte_ok && (byte_cnt == 2'd3);
      if (byte_ok) begin
        asm_word <= {asm_word[23:0], shreg};
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

  // Memory write strobe, address advance and completion tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_adr   <= '0;
      memdata   <= '0;
      last_word <= '0;
      done      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (word_rdy && !done) begin
        if (asm_word == TERM_WORD) begin
          done <= 1'b1;
        end else begin
          mem_we  <= 1'b1;
          memdata <= asm_word;
          // last slot: done rises together with its write strobe
          if (mem_adr == ADR_MAX) done <= 1'b1;
        end
      end
      if (mem_we) begin
        last_word <= memdata;
        if (mem_adr != ADR_MAX) mem_adr <= mem_adr + 1'b1;
      end
    end
  end

  // CPU reset releases one cycle after loading completes
  always_ff @(posedge clk) begin
    if (reset) cpu_reset <= 1'b1;
    else       cpu_reset <= ~done;
  end

  assign rx_check  = {done, last_word};
  assign rx_checkh = {frame_err, 16'b0, asm_word[31:16]};
  assign rx_checkl = {1'b0, 24'b0, 6'b0, byte_cnt};

endmodule
